// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants, FSM state type and source-address helper for the OAM DMA engine.
package oam_dma_ctrl_pkg;

  localparam logic [15:0] ADDR_DMA_REG  = 16'hFF46;
  localparam logic [15:0] ADDR_OAM_BASE = 16'hFE00;
  localparam logic [8:0]  HRAM_PREFIX   = 9'h1FF;
  localparam logic [15:0] ECHO_OFFSET   = 16'h2000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_READ,
    ST_WAIT,
    ST_WRITE
  } dma_state_t;

  // E000-FFFF pages mirror C000-DFFF, so the copy reads from the work RAM image.
  function automatic logic [15:0] dma_src_base(input logic [7:0] page);
    logic [15:0] base;
    base = {page, 8'h00};
    if (base[15:13] == 3'b111) begin
      base = base - ECHO_OFFSET;
    end
    return base;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and mmu-side bus signals of the OAM DMA engine, bundled with modports.
interface oam_dma_ctrl_if;

  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  oCpuData;
  logic [15:0] oMmuAddr;
  logic        oMmuWe;
  logic [7:0]  oMmuData;
  logic [7:0]  iMmuData;
  logic [7:0]  oDmaReg;
  logic        oDmaBusy;

  modport slave (
    input  iCpuAddr, iCpuWe, iCpuData, iMmuData,
    output oCpuData, oMmuAddr, oMmuWe, oMmuData, oDmaReg, oDmaBusy
  );

  modport master (
    output iCpuAddr, iCpuWe, iCpuData, iMmuData,
    input  oCpuData, oMmuAddr, oMmuWe, oMmuData, oDmaReg, oDmaBusy
  );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Gameboy OAM DMA engine: copies XX00-XX9F to FE00-FE9F after an FF46 write and
// arbitrates the single mmu port between the CPU and the copy engine.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = 160,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned START_DELAY  = 1
) (
  input  logic           iClock,
  input  logic           iReset,
  oam_dma_ctrl_if.slave  bus
);

  localparam logic [7:0] LAST_IDX   = 8'(NUM_BYTES - 1);
  localparam logic [7:0] WAIT_LOAD  = 8'(READ_LATENCY - 1);
  localparam logic [7:0] START_LOAD = 8'((START_DELAY == 0) ? 0 : START_DELAY - 1);

  dma_state_t              r_state;
  logic [7:0]              r_index;
  logic [15:0]             r_src;
  logic [7:0]              r_byte;
  logic [7:0]              r_cnt;
  logic [7:0]              r_dma_reg;
  logic                    r_busy;
  logic [READ_LATENCY-1:0] r_blk_sr;

  logic w_hram;
  logic w_dmareg;
  logic w_dma_wr;
  logic w_stall;
  logic w_blocked;

  assign w_hram    = (bus.iCpuAddr[15:7] == HRAM_PREFIX);
  assign w_dmareg  = (bus.iCpuAddr == ADDR_DMA_REG);
  assign w_dma_wr  = w_dmareg && bus.iCpuWe;
  // HRAM traffic only collides with the DMA in the cycles where the DMA owns the port.
  assign w_stall   = ((r_state == ST_READ) || (r_state == ST_WRITE)) && w_hram;
  assign w_blocked = (r_state != ST_IDLE) && !w_hram && !w_dmareg;

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_state   <= ST_IDLE;
      r_index   <= '0;
      r_src     <= '0;
      r_byte    <= '0;
      r_cnt     <= '0;
      r_dma_reg <= '1;
      r_busy    <= 1'b0;
      r_blk_sr  <= '0;
    end else begin
      r_blk_sr[0] <= w_blocked;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_blk_sr[i] <= r_blk_sr[i-1];
      end

      // An FF46 write restarts the copy from any state, including the final WRITE.
      if (w_dma_wr) begin
        r_dma_reg <= bus.iCpuData;
        r_src     <= dma_src_base(bus.iCpuData);
        r_index   <= '0;
        r_busy    <= 1'b1;
        if (START_DELAY == 0) begin
          r_state <= ST_READ;
        end else begin
          r_state <= ST_START;
          r_cnt   <= START_LOAD;
        end
      end else if (!w_stall) begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_START: begin
            if (r_cnt == '0) begin
              r_state <= ST_READ;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          ST_READ: begin
            r_state <= ST_WAIT;
            r_cnt   <= WAIT_LOAD;
          end
          ST_WAIT: begin
            if (r_cnt == '0) begin
              r_byte  <= bus.iMmuData;
              r_state <= ST_WRITE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          ST_WRITE: begin
            if (r_index == LAST_IDX) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_index <= r_index + 8'd1;
              r_state <= ST_READ;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.oMmuAddr = bus.iCpuAddr;
    bus.oMmuWe   = 1'b0;
    bus.oMmuData = bus.iCpuData;
    case (r_state)
      ST_IDLE: begin
        bus.oMmuWe = bus.iCpuWe && !w_dmareg;
      end
      ST_READ: begin
        if (w_hram) begin
          bus.oMmuWe = bus.iCpuWe;
        end else begin
          bus.oMmuAddr = r_src + {8'h00, r_index};
        end
      end
      ST_WRITE: begin
        if (w_hram) begin
          bus.oMmuWe = bus.iCpuWe;
        end else begin
          bus.oMmuAddr = ADDR_OAM_BASE + {8'h00, r_index};
          bus.oMmuWe   = 1'b1;
          bus.oMmuData = r_byte;
        end
      end
      default: begin
        bus.oMmuWe = bus.iCpuWe && w_hram;
      end
    endcase
  end

  assign bus.oCpuData = r_blk_sr[READ_LATENCY-1] ? 8'hFF : bus.iMmuData;
  assign bus.oDmaReg  = r_dma_reg;
  assign bus.oDmaBusy = r_busy;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus queues expected mmu writes and CPU
// read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_oam_dma_ctrl;

  localparam int NB  = 160;
  localparam int RL  = 1;
  localparam int SD  = 1;
  localparam int PER = 2 + RL;

  logic iClock = 1'b0;
  logic iReset = 1'b0;
  always #5 iClock = ~iClock;

  oam_dma_ctrl_if bus();

  oam_dma_ctrl #(
    .NUM_BYTES   (NB),
    .READ_LATENCY(RL),
    .START_DELAY (SD)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       tb_rd = 1'b0;
  logic       rd_d  = 1'b0;
  logic [7:0] salt;

  logic [7:0] mmu_mem [0:65535];
  bit         mmu_wr  [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         ref_wr  [0:65535];

  function automatic logic [7:0] pattern(input logic [15:0] a);
    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ salt;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : pattern(a);
  endfunction

  function automatic wr_t mk_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Reference rule for the source page: E0-FF pages read the C000-DFFF image.
  function automatic logic [15:0] src_of(input logic [7:0] page);
    logic [15:0] b;
    b = {page, 8'h00};
    if (page >= 8'hE0) b = b - 16'h2000;
    return b;
  endfunction

  // Synchronous mmu memory with one cycle of read latency.
  always @(posedge iClock) begin
    if (bus.oMmuWe === 1'b1) begin
      mmu_mem[bus.oMmuAddr] <= bus.oMmuData;
      mmu_wr[bus.oMmuAddr]  <= 1'b1;
    end
    bus.iMmuData <= mmu_wr[bus.oMmuAddr] ? mmu_mem[bus.oMmuAddr] : pattern(bus.oMmuAddr);
  end

  always @(posedge iClock) rd_d <= tb_rd;

  always @(negedge iClock) begin
    wr_t        e;
    logic [7:0] r;
    if (bus.oMmuWe === 1'b1) begin
      n_vec++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_mmu_write: got addr=%h data=%h, required no write", bus.oMmuAddr, bus.oMmuData);
      end else begin
        e = wq.pop_front();
        if (bus.oMmuAddr !== e.a || bus.oMmuData !== e.d) begin
          n_err++;
          $display("FAIL mmu_write: got addr=%h data=%h, required addr=%h data=%h", bus.oMmuAddr, bus.oMmuData, e.a, e.d);
        end
      end
    end
    if (rd_d) begin
      n_vec++;
      if (rq.size() == 0) begin
        n_err++;
        $display("FAIL cpu_read: no expected value queued, got %h", bus.oCpuData);
      end else begin
        r = rq.pop_front();
        if (bus.oCpuData !== r) begin
          n_err++;
          $display("FAIL cpu_read: got %h, required %h", bus.oCpuData, r);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic drive_idle();
    bus.iCpuAddr = 16'h8000;
    bus.iCpuWe   = 1'b0;
    bus.iCpuData = 8'h00;
    tb_rd        = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.iCpuAddr = a;
    bus.iCpuWe   = 1'b1;
    bus.iCpuData = d;
    tb_rd        = 1'b0;
    wq.push_back(mk_wr(a, d));
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    bus.iCpuAddr = a;
    bus.iCpuWe   = 1'b0;
    bus.iCpuData = 8'h00;
    tb_rd        = 1'b1;
    rq.push_back(ref_rd(a));
  endtask

  task automatic rand_idle_ops(input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(3))
        0: cpu_write(16'hC000 + 16'($urandom_range(16'h1FFF)), 8'($urandom));
        1: cpu_write(16'hFF80 + 16'($urandom_range(126)), 8'($urandom));
        2: begin
          a = $urandom_range(1) ? 16'hC000 + 16'($urandom_range(16'h1FFF))
                                : 16'hFF80 + 16'($urandom_range(126));
          cpu_read(a);
        end
        default: drive_idle();
      endcase
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic push_transfer(input logic [15:0] src);
    for (int i = 0; i < NB; i++) begin
      wq.push_back(mk_wr(16'hFE00 + 16'(i), ref_rd(src + 16'(i))));
    end
  endtask

  task automatic dma_test(input logic [7:0] page, input int stall_byte_in, input int rst_cyc_in,
                          input logic [7:0] rpage, input int reset_byte, input bit noise);
    int          c, dur, we_cnt, stall_byte, rst_cyc;
    logic [15:0] src;
    logic [7:0]  d;
    bit          hold_chk, done, do_stall, do_rst, do_reset;
    stall_byte   = stall_byte_in;
    rst_cyc      = rst_cyc_in;
    bus.iCpuAddr = 16'hFF46;
    bus.iCpuWe   = 1'b1;
    bus.iCpuData = page;
    tb_rd        = 1'b0;
    step();
    src = src_of(page);
    push_transfer(src);
    chk("busy_after_ff46", 32'(bus.oDmaBusy), 32'd1);
    chk("dmareg_after_ff46", 32'(bus.oDmaReg), 32'(page));
    dur      = SD + NB * PER;
    c        = 0;
    hold_chk = 1'b0;
    done     = 1'b0;
    while (!done && c < 3000) begin
      do_stall = (stall_byte >= 0) && (c == SD + PER * stall_byte);
      do_rst   = (c == rst_cyc);
      do_reset = (reset_byte >= 0) && (c == SD + PER * reset_byte);
      drive_idle();
      if (do_stall) begin
        d = 8'($urandom);
        bus.iCpuAddr = 16'hFF80;
        bus.iCpuWe   = 1'b1;
        bus.iCpuData = d;
        wq.push_front(mk_wr(16'hFF80, d));
        ref_mem[16'hFF80] = d;
        ref_wr[16'hFF80]  = 1'b1;
        dur++;
      end else if (do_rst) begin
        bus.iCpuAddr = 16'hFF46;
        bus.iCpuWe   = 1'b1;
        bus.iCpuData = rpage;
      end else if (do_reset) begin
        iReset = 1'b0;
      end else if (noise) begin
        if (c == 5) begin
          bus.iCpuAddr = 16'h8000;
          tb_rd = 1'b1;
          rq.push_back(8'hFF);
        end else if (c == 7) begin
          bus.iCpuAddr = 16'hC000;
          bus.iCpuWe   = 1'b1;
          bus.iCpuData = 8'h5A;
        end else if ($urandom_range(3) == 0) begin
          bus.iCpuAddr = 16'h8000 + 16'($urandom_range(16'h5FFF));
          if ($urandom_range(1) == 1) begin
            bus.iCpuWe   = 1'b1;
            bus.iCpuData = 8'($urandom);
          end else begin
            tb_rd = 1'b1;
            rq.push_back(8'hFF);
          end
        end
      end
      #1;
      if (c == SD) begin
        chk("first_read_addr", 32'(bus.oMmuAddr), 32'(src));
        chk("first_read_we", 32'(bus.oMmuWe), 32'd0);
      end
      if (hold_chk) begin
        chk("stall_hold_addr", 32'(bus.oMmuAddr), 32'(src + 16'(stall_byte)));
        chk("stall_hold_we", 32'(bus.oMmuWe), 32'd0);
      end
      hold_chk = do_stall;
      step();
      c++;
      if (do_rst) begin
        wq.delete();
        src = src_of(rpage);
        push_transfer(src);
        chk("busy_after_restart", 32'(bus.oDmaBusy), 32'd1);
        chk("dmareg_after_restart", 32'(rpage), 32'(bus.oDmaReg));
        c          = 0;
        dur        = SD + NB * PER;
        rst_cyc    = -1;
        stall_byte = -1;
      end else if (do_reset) begin
        iReset = 1'b1;
        wq.delete();
        chk("busy_after_reset", 32'(bus.oDmaBusy), 32'd0);
        chk("dmareg_after_reset", 32'(bus.oDmaReg), 32'hFF);
        we_cnt = 0;
        for (int k = 0; k < 20; k++) begin
          step();
          if (bus.oMmuWe === 1'b1) we_cnt++;
        end
        chk("no_dma_we_after_reset", 32'(we_cnt), 32'd0);
        done = 1'b1;
      end else if (!bus.oDmaBusy) begin
        chk("busy_cycles", 32'(c), 32'(dur));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL dma_timeout: busy still %b after %0d cycles, required low after %0d", bus.oDmaBusy, c, dur);
    end
    drive_idle();
  endtask

  initial begin
    salt   = 8'($urandom);
    iReset = 1'b0;
    drive_idle();
    bus.iMmuData = 8'h00;
    repeat (3) step();
    chk("reset_busy", 32'(bus.oDmaBusy), 32'd0);
    chk("reset_dmareg", 32'(bus.oDmaReg), 32'hFF);
    iReset = 1'b1;
    step();

    cpu_write(16'hC000, 8'h5A);
    #1;
    chk("idle_pass_addr", 32'(bus.oMmuAddr), 32'hC000);
    chk("idle_pass_we", 32'(bus.oMmuWe), 32'd1);
    step();
    rand_idle_ops(40);

    dma_test(8'hC1, -1, -1, 8'h00, -1, 1'b1);
    rand_idle_ops(20);
    dma_test(8'(8'h80 + $urandom_range(8'h5F)), 10, -1, 8'h00, -1, 1'b1);
    rand_idle_ops(10);
    dma_test(8'(8'hC0 + $urandom_range(8'h1F)), -1, SD + PER * 50, 8'hD0, -1, 1'b1);
    dma_test(8'hE5, -1, -1, 8'h00, -1, 1'b0);
    dma_test(8'($urandom_range(8'hDF)), -1, SD + PER * (NB - 1) + 2, 8'(8'hC0 + $urandom_range(8'h1F)), -1, 1'b1);
    rand_idle_ops(10);
    dma_test(8'(8'hC0 + $urandom_range(8'h1F)), -1, -1, 8'h00, 80, 1'b1);
    rand_idle_ops(30);

    repeat (5) step();
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
